// File: rtl/encoder_8to3_seq_pkg.sv
// Shared types and defaults for the sequential 8-to-3 priority encoder.
// Holds the state encoding, default widths and a popcount helper.
package encoder_8to3_seq_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic logic [3:0] popcnt(
    input logic [N_DEF-1:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_DEF; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/encoder_8to3_seq_pri.sv
// Combinational priority encoder: index of the highest set bit.
// 'any' flags a non-empty vector.
module pri_enc_8to3
  import encoder_8to3_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [N-1:0] pending,
  output logic [W-1:0] y,
  output logic         any
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    y   = '0;
    any = |pending;
    for (int i = 0; i < N; i++)
      if (pending[i]) y = W'(i);
  end

endmodule

// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: one index per beat, highest bit first.
// Define ENC_POPCNT_EN to add the cnt popcount output.
module encoder_8to3_seq
  import encoder_8to3_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
`ifdef ENC_POPCNT_EN
  ,
  output logic [3:0]   cnt
`endif
);

  state_t         state;
  logic [N-1:0]   pending;
  logic [W-1:0]   idx;
  logic           any;
  logic           one_hot;
  logic           fire_in;
  logic           fire_out;
  logic [N-1:0]   cleared;

  pri_enc_8to3 #(
    .N(N),
    .W(W)
  ) u_pri (
    .pending(pending),
    .y      (idx),
    .any    (any)
  );

  assign one_hot   = any & ~|(pending & (pending - N'(1)));
  assign out_valid = (state == ST_DRAIN);
  assign y         = out_valid ? idx : '0;
  assign out_last  = out_valid & one_hot;

  // Accepting on the last beat lets vectors flow with no idle bubble.
  assign in_ready  = (state == ST_IDLE)
                   | (out_valid & out_ready & out_last);
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = out_valid & out_ready;
  assign cleared   = pending & ~(N'(1) << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      if (fire_out) begin
        pending <= cleared;
        if (out_last) state <= ST_IDLE;
      end
      if (fire_in && |a) begin
        pending <= a;
        state   <= ST_DRAIN;
      end
    end
  end

`ifdef ENC_POPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (fire_in && |a)
      cnt <= popcnt(a);
  end
`endif

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Scoreboard bench for encoder_8to3_seq.
// Optional cnt checks follow ENC_POPCNT_EN.
module tb_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] y;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
`ifdef ENC_POPCNT_EN
  logic [3:0] cnt;
  logic [3:0] cnt_exp = '0;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];
  bit toggle_rdy = 0;
  bit mon_en = 0;

  encoder_8to3_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
`ifdef ENC_POPCNT_EN
    ,
    .cnt      (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_beats(input logic [7:0] v);
    int left;
    left = $countones(v);
    for (int i = 7; i >= 0; i--)
      if (v[i]) begin
        sb.push_back({3'(i), left == 1});
        left--;
      end
  endtask

  // Called at posedge+1; leaves in_valid high with a at capture.
  task automatic send(input logic [7:0] v);
    bit acc;
    acc = 0;
    a = v;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        push_beats(v);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
`ifdef ENC_POPCNT_EN
    if (acc && v != 0) cnt_exp = 4'($countones(v));
    check("cnt", cnt, cnt_exp);
`endif
  endtask

  task automatic drop_in();
    in_valid = 1'b0;
    a = '0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (toggle_rdy) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // Monitor: compare consumed beats, y=0 when idle, stall stability.
  logic       st_prev = 0;
  logic [3:0] st_val;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (st_prev)
        check("stall_hold", {out_valid, y, out_last}, {1'b1, st_val});
      if (!out_valid)
        check("y_idle", y, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("extra_beat", {y, out_last}, 0);
        else check("beat", {y, out_last}, sb.pop_front());
      end
      st_prev = out_valid && !out_ready;
      st_val  = {y, out_last};
    end else begin
      st_prev = 0;
    end
  end

  initial begin
    // 1: reset held with a valid request present
    a = 8'hFF;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef ENC_POPCNT_EN
    check("rst_cnt", cnt, 0);
`endif
    drop_in();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;
    check("post_rst_idle", out_valid, 0);

    // 2: two set bits, in_ready only on the last beat
    send(8'b0010_0100);
    drop_in();
    @(negedge clk);
    check("t2_y5", y, 5);
    check("t2_rdy0", in_ready, 0);
    @(negedge clk);
    check("t2_y2", y, 2);
    check("t2_rdy1", in_ready, 1);
    wait_drain();

    // 3: full vector with stalling consumer, next vector held off
    toggle_rdy = 1;
    send(8'hFF);
    send(8'h81);
    drop_in();
    wait_drain();
    toggle_rdy = 0;
    @(posedge clk);
    #1;

    // 4: back-to-back single-bit vectors
    send(8'h01);
    send(8'h80);
    drop_in();
    check("b2b_valid", out_valid, 1);
    check("b2b_y7", y, 7);
    wait_drain();

    // 5: empty vector accepted silently
    send(8'h00);
    drop_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_no_beat", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(8'h80);
    drop_in();
    wait_drain();

    // 6: reset in the middle of a drain
    send(8'hF0);
    drop_in();
    begin
      bit hit;
      hit = 0;
      for (int t = 0; t < 20 && !hit; t++) begin
        @(negedge clk);
        if (out_valid && y == 3'd6) hit = 1;
      end
      check("mid_seen_y6", hit, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef ENC_POPCNT_EN
    cnt_exp = '0;
`endif
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(8'h03);
    drop_in();
    wait_drain();
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
